// File: rtl/div_restore_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div_restore_seq_ctrl
// Iterative restoring divider with its own controller. It computes one
// quotient bit per clock, MSB first, so an N-bit job takes N cycles.
// Use it instead of the unrolled combinational divider wherever a
// multi-cycle result is acceptable.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   in_valid   job request
//   in_ready   high while idle (and out of reset); a job is taken on
//              in_valid && in_ready
//   dividend   N-bit unsigned dividend, sampled on the input handshake
//   divisor    M-bit unsigned divisor, sampled on the input handshake
//   flush      synchronous abort of the job in flight (ignored when idle)
//   out_valid  result available
//   out_ready  consumer accepts the result
//   q          N-bit quotient
//   rem        M-bit remainder
//   dbz        divide-by-zero flag belonging to the presented result
// ---------------------------------------------------------------------------
module div_restore_seq_ctrl #(
   parameter int N = 8,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] dividend,
   input  logic [M-1:0] divisor,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] q,
   output logic [M-1:0] rem,
   output logic         dbz
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q;

   // Working registers used while a job is running.
   logic [N-1:0]   dvdShift_q;
   logic [N-1:0]   quoWork_q;
   logic [M:0]     partRem_q;
   logic [M-1:0]   dvsr_q;
   logic           dbzWork_q;
   logic [CW-1:0]  count_q;

   // Registered outputs. The result registers are only written when a
   // job completes, so they keep showing the previous result while the
   // next job runs, and are left untouched by a flush.
   logic           inReady_q;
   logic           outValid_q;
   logic [N-1:0]   quo_q;
   logic [M-1:0]   rem_q;
   logic           dbz_q;

   // One restoring step: bring in the next dividend bit, try subtracting
   // the divisor, and keep the difference only when it did not borrow.
   logic [M:0]     trialIn;
   logic [M+1:0]   trialDiff;
   logic           borrow;
   logic [M:0]     partRem_d;
   logic [N-1:0]   quoWork_d;

   // With divisor == 0 the trial never borrows, so the quotient fills with
   // ones and the remainder ends up as the low M dividend bits; that is the
   // defined divide-by-zero result, so no special path is needed.
   always_comb begin
      trialIn   = {partRem_q[M-1:0], dvdShift_q[N-1]};
      trialDiff = {1'b0, trialIn} - {2'b00, dvsr_q};
      borrow    = trialDiff[M+1];
      partRem_d = borrow ? trialIn : trialDiff[M:0];
      quoWork_d = {quoWork_q[N-2:0], ~borrow};
   end

   // Controller and datapath registers. in_ready comes from a register so
   // that it reads 0 during reset and rises on the first edge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dvdShift_q <= '0;
         quoWork_q  <= '0;
         partRem_q  <= '0;
         dvsr_q     <= '0;
         dbzWork_q  <= 1'b0;
         count_q    <= '0;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         quo_q      <= '0;
         rem_q      <= '0;
         dbz_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               inReady_q <= 1'b1;
               if (in_valid && inReady_q) begin
                  dvdShift_q <= dividend;
                  dvsr_q     <= divisor;
                  partRem_q  <= '0;
                  quoWork_q  <= '0;
                  dbzWork_q  <= (divisor == '0);
                  count_q    <= CW'(N - 1);
                  inReady_q  <= 1'b0;
                  state_q    <= RUN;
               end
            end

            RUN: begin
               if (flush) begin
                  inReady_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  partRem_q  <= partRem_d;
                  quoWork_q  <= quoWork_d;
                  dvdShift_q <= {dvdShift_q[N-2:0], 1'b0};
                  if (count_q == '0) begin
                     quo_q      <= quoWork_d;
                     rem_q      <= partRem_d[M-1:0];
                     dbz_q      <= dbzWork_q;
                     outValid_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     count_q <= count_q - CW'(1);
                  end
               end
            end

            DONE: begin
               if (flush || out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= IDLE;
               end
            end

            default: begin
               outValid_q <= 1'b0;
               inReady_q  <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign q         = quo_q;
   assign rem       = rem_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_div_restore_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_div_restore_seq_ctrl
// Directed bench for div_restore_seq_ctrl. A default 8/4 instance covers
// the main scenarios; a 2/1 instance is swept exhaustively against a
// small golden model. Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_div_restore_seq_ctrl;

   logic       clk;
   logic       rst_n;

   // 8-bit / 4-bit instance
   logic       inValid;
   logic       inReady;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       flush;
   logic       outValid;
   logic       outReady;
   logic [7:0] q;
   logic [3:0] rem;
   logic       dbz;

   // 2-bit / 1-bit instance
   logic       sInValid;
   logic       sInReady;
   logic [1:0] sDividend;
   logic [0:0] sDivisor;
   logic       sFlush;
   logic       sOutValid;
   logic       sOutReady;
   logic [1:0] sQ;
   logic [0:0] sRem;
   logic       sDbz;

   int errors;
   int checks;

   div_restore_seq_ctrl #(.N(8), .M(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .out_valid (outValid),
      .out_ready (outReady),
      .q         (q),
      .rem       (rem),
      .dbz       (dbz)
   );

   div_restore_seq_ctrl #(.N(2), .M(1)) dutSmall (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sInValid),
      .in_ready  (sInReady),
      .dividend  (sDividend),
      .divisor   (sDivisor),
      .flush     (sFlush),
      .out_valid (sOutValid),
      .out_ready (sOutReady),
      .q         (sQ),
      .rem       (sRem),
      .dbz       (sDbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Wait (bounded) for in_ready, then present one job at a falling edge.
   // Returns 1ns after the handshake edge.
   task automatic startJob(input logic [7:0] dvd, input logic [3:0] dvs);
      int guard;
      guard = 0;
      while (!inReady && guard < 40) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!inReady) begin
         errors++;
         checks++;
         $display("[TB] FAIL startJob_ready_timeout: in_ready=%0b required 1", inReady);
      end
      @(negedge clk);
      dividend = dvd;
      divisor  = dvs;
      inValid  = 1'b1;
      @(posedge clk);
      #1;
      inValid  = 1'b0;
      dividend = 8'h00;
      divisor  = 4'h0;
   endtask

   // Count clock edges after the handshake until out_valid is seen.
   task automatic waitOutValid(output int cycles);
      cycles = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (outValid) begin
            cycles = c;
            break;
         end
      end
      if (cycles < 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL out_valid_timeout: out_valid=%0b required 1", outValid);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      inValid   = 1'b0;
      dividend  = '0;
      divisor   = '0;
      flush     = 1'b0;
      outReady  = 1'b1;
      sInValid  = 1'b0;
      sDividend = '0;
      sDivisor  = '0;
      sFlush    = 1'b0;
      sOutReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({inReady, outValid, q, rem, dbz} !== 15'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got rdy=%0b vld=%0b q=%0d rem=%0d dbz=%0b required all 0",
                  inReady, outValid, q, rem, dbz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_ready: in_ready=%0b required 1", inReady);
      end
   endtask

   task automatic test_basic();
      int cyc;
      startJob(8'd200, 4'd7);
      waitOutValid(cyc);
      checks++;
      if (cyc !== 8) begin
         errors++;
         $display("[TB] FAIL basic_latency: got %0d cycles required 8", cyc);
      end
      checks++;
      if (q !== 8'd28 || rem !== 4'd4 || dbz !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_result: got q=%0d rem=%0d dbz=%0b required q=28 rem=4 dbz=0", q, rem, dbz);
      end
      checks++;
      if (inReady !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_busy_ready: in_ready=%0b required 0", inReady);
      end
      // out_ready is high: the next edge returns to IDLE.
      @(posedge clk);
      #1;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_return_idle: vld=%0b rdy=%0b required vld=0 rdy=1", outValid, inReady);
      end
      // A new job is accepted on the following edge, two edges after
      // out_valid rose, i.e. one job per N+2 cycles.
      @(negedge clk);
      dividend = 8'd10;
      divisor  = 4'd3;
      inValid  = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checks++;
      if (inReady !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_next_accept: in_ready=%0b required 0", inReady);
      end
      waitOutValid(cyc);
      checks++;
      if (q !== 8'd3 || rem !== 4'd1) begin
         errors++;
         $display("[TB] FAIL basic_second_job: got q=%0d rem=%0d required q=3 rem=1", q, rem);
      end
   endtask

   task automatic test_div_by_zero();
      int cyc;
      startJob(8'hA5, 4'd0);
      waitOutValid(cyc);
      checks++;
      if (q !== 8'hFF || rem !== 4'h5 || dbz !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dbz_result: got q=%0h rem=%0h dbz=%0b required q=ff rem=5 dbz=1", q, rem, dbz);
      end
   endtask

   task automatic test_exhaustive_small();
      logic [1:0] expQ;
      logic [0:0] expRem;
      logic       expDbz;
      int         cyc;
      for (int dv = 0; dv < 4; dv++) begin
         for (int ds = 0; ds < 2; ds++) begin
            if (ds == 0) begin
               expQ   = 2'b11;
               expRem = 1'(dv % 2);
               expDbz = 1'b1;
            end else begin
               expQ   = 2'(dv);
               expRem = 1'b0;
               expDbz = 1'b0;
            end
            @(negedge clk);
            sDividend = 2'(dv);
            sDivisor  = 1'(ds);
            sInValid  = 1'b1;
            @(posedge clk);
            #1;
            sInValid = 1'b0;
            cyc = -1;
            for (int c = 1; c <= 20; c++) begin
               @(posedge clk);
               #1;
               if (sOutValid) begin
                  cyc = c;
                  break;
               end
            end
            checks++;
            if (cyc !== 2) begin
               errors++;
               $display("[TB] FAIL small_latency %0d/%0d: got %0d cycles required 2", dv, ds, cyc);
            end
            checks++;
            if (sQ !== expQ || sRem !== expRem || sDbz !== expDbz) begin
               errors++;
               $display("[TB] FAIL small_result %0d/%0d: got q=%0d rem=%0d dbz=%0b required q=%0d rem=%0d dbz=%0b",
                        dv, ds, sQ, sRem, sDbz, expQ, expRem, expDbz);
            end
            // out_ready is high, so one more edge returns to IDLE.
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      outReady = 1'b0;
      startJob(8'd100, 4'd9);
      waitOutValid(cyc);
      checks++;
      if (q !== 8'd11 || rem !== 4'd1 || dbz !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_result: got q=%0d rem=%0d dbz=%0b required q=11 rem=1 dbz=0", q, rem, dbz);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         dividend = 8'd77;
         divisor  = 4'd2;
         inValid  = 1'b1;
         @(posedge clk);
         #1;
         checks++;
         if (outValid !== 1'b1 || inReady !== 1'b0 || q !== 8'd11 || rem !== 4'd1 || dbz !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold cycle %0d: got vld=%0b rdy=%0b q=%0d rem=%0d dbz=%0b required vld=1 rdy=0 q=11 rem=1 dbz=0",
                     i, outValid, inReady, q, rem, dbz);
         end
      end
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_release: vld=%0b rdy=%0b required vld=0 rdy=1", outValid, inReady);
      end
      startJob(8'd50, 4'd3);
      waitOutValid(cyc);
      checks++;
      if (q !== 8'd16 || rem !== 4'd2) begin
         errors++;
         $display("[TB] FAIL bp_next_job: got q=%0d rem=%0d required q=16 rem=2", q, rem);
      end
   endtask

   task automatic test_flush();
      int  cyc;
      bit  sawValid;
      startJob(8'd200, 4'd7);
      // Steps 1 and 2 run, flush lands on the edge of step 3.
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (inReady !== 1'b1 || outValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_to_idle: rdy=%0b vld=%0b required rdy=1 vld=0", inReady, outValid);
      end
      sawValid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (outValid) sawValid = 1'b1;
      end
      checks++;
      if (sawValid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_no_result: out_valid seen=%0b required 0", sawValid);
      end
      checks++;
      if (q !== 8'd16 || rem !== 4'd2) begin
         errors++;
         $display("[TB] FAIL flush_keeps_last: got q=%0d rem=%0d required q=16 rem=2", q, rem);
      end
      startJob(8'd15, 4'd4);
      waitOutValid(cyc);
      checks++;
      if (q !== 8'd3 || rem !== 4'd3 || dbz !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_next_job: got q=%0d rem=%0d dbz=%0b required q=3 rem=3 dbz=0", q, rem, dbz);
      end
   endtask

   task automatic test_reset_midjob();
      int cyc;
      startJob(8'd200, 4'd7);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({inReady, outValid, q, rem, dbz} !== 15'h0) begin
         errors++;
         $display("[TB] FAIL reset_in_run: got rdy=%0b vld=%0b q=%0d rem=%0d dbz=%0b required all 0",
                  inReady, outValid, q, rem, dbz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      outReady = 1'b0;
      startJob(8'hA5, 4'd0);
      waitOutValid(cyc);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({inReady, outValid, q, rem, dbz} !== 15'h0) begin
         errors++;
         $display("[TB] FAIL reset_in_done: got rdy=%0b vld=%0b q=%0d rem=%0d dbz=%0b required all 0",
                  inReady, outValid, q, rem, dbz);
      end
      @(negedge clk);
      rst_n = 1'b1;
      outReady = 1'b1;
      startJob(8'd123, 4'd5);
      waitOutValid(cyc);
      checks++;
      if (cyc !== 8 || q !== 8'd24 || rem !== 4'd3 || dbz !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_recover: got cyc=%0d q=%0d rem=%0d dbz=%0b required cyc=8 q=24 rem=3 dbz=0",
                  cyc, q, rem, dbz);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_basic();
      @(posedge clk);
      #1;
      test_div_by_zero();
      test_exhaustive_small();
      test_backpressure();
      test_flush();
      test_reset_midjob();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
